// File: rtl/counter_mod_updn.sv
// ---------------------------------------------------------------------------
// counter_mod_updn
//
// Parametrised WIDTH-bit up/down counter with a programmable modulus.
// The count range is 0..modulus inclusive. Supports synchronous clear,
// parallel load (clamped to modulus), count enable, and a per-cycle choice
// between wrapping and saturating at the range boundaries.
//
// Parameters:
//   WIDTH      counter width in bits (>= 2)
//   RESET_VAL  value loaded into cnt by the asynchronous reset
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   clr       in   synchronous clear to 0 (highest priority)
//   load      in   synchronous load of min(load_val, modulus)
//   load_val  in   [WIDTH] load value
//   en        in   count enable
//   up_dn     in   1 = count up, 0 = count down
//   modulus   in   [WIDTH] terminal value
//   sat_mode  in   1 = saturate at boundary, 0 = wrap
//   cnt       out  [WIDTH] registered count
//   tc        out  combinational terminal-count flag for the current direction
//   wrap      out  registered one-cycle pulse, high alongside the post-wrap cnt
//
// Optional build macro CNT_SNAPSHOT_EN adds:
//   snap      in   capture request
//   snap_val  out  [WIDTH] cnt value sampled on the last edge with snap=1
// ---------------------------------------------------------------------------
module counter_mod_updn #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] modulus,
    input  logic             sat_mode,
`ifdef CNT_SNAPSHOT_EN
    input  logic             snap,
    output logic [WIDTH-1:0] snap_val,
`endif
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    logic [WIDTH-1:0] cnt_nxt;
    logic             wrap_nxt;

    // Boundary comparisons, all unsigned at WIDTH bits. cnt can sit above
    // modulus when modulus is lowered mid-run, so "at or above" is used
    // for the top boundary rather than equality.
    logic             at_or_above_top;
    logic             above_top;
    logic             at_zero;
    logic [WIDTH-1:0] load_clamped;

    assign at_or_above_top = (cnt >= modulus);
    assign above_top       = (cnt >  modulus);
    assign at_zero         = (cnt == ZERO);
    assign load_clamped    = (load_val > modulus) ? modulus : load_val;

    assign tc = up_dn ? at_or_above_top : at_zero;

    // Next count for an enabled step upward. cnt+1 is only taken when
    // cnt < modulus, so it can never overflow WIDTH bits.
    logic [WIDTH-1:0] up_cnt;
    logic             up_wrap;

    always_comb begin
        up_cnt  = cnt;
        up_wrap = 1'b0;
        if (!at_or_above_top) begin
            up_cnt = cnt + ONE;
        end else if (sat_mode) begin
            up_cnt = modulus;
        end else begin
            up_cnt  = ZERO;
            up_wrap = 1'b1;
        end
    end

    // Next count for an enabled step downward. A count left above a newly
    // lowered modulus is pulled back to modulus without flagging a wrap.
    logic [WIDTH-1:0] dn_cnt;
    logic             dn_wrap;

    always_comb begin
        dn_cnt  = cnt;
        dn_wrap = 1'b0;
        if (above_top) begin
            dn_cnt = modulus;
        end else if (!at_zero) begin
            dn_cnt = cnt - ONE;
        end else if (sat_mode) begin
            dn_cnt = ZERO;
        end else begin
            dn_cnt  = modulus;
            dn_wrap = 1'b1;
        end
    end

    // Priority: clr > load > en > hold. wrap only ever comes from a step.
    always_comb begin
        cnt_nxt  = cnt;
        wrap_nxt = 1'b0;
        if (clr) begin
            cnt_nxt = ZERO;
        end else if (load) begin
            cnt_nxt = load_clamped;
        end else if (en) begin
            if (up_dn) begin
                cnt_nxt  = up_cnt;
                wrap_nxt = up_wrap;
            end else begin
                cnt_nxt  = dn_cnt;
                wrap_nxt = dn_wrap;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= RESET_VAL;
            wrap <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            wrap <= wrap_nxt;
        end
    end

`ifdef CNT_SNAPSHOT_EN
    // Captures the pre-update count of the same edge; clr/load do not touch it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_val <= ZERO;
        end else if (snap) begin
            snap_val <= cnt;
        end
    end
`endif

endmodule

// File: tb/tb_counter_mod_updn.sv
module tb_counter_mod_updn;

    localparam int WIDTH = 8;
    localparam int RVAL  = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clr, en, up_dn, load, sat_mode;
    logic [WIDTH-1:0] load_val, modulus;
    logic [WIDTH-1:0] cnt;
    logic             tc, wrap;
`ifdef CNT_SNAPSHOT_EN
    logic             snap;
    logic [WIDTH-1:0] snap_val;
    int               m_snap;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    // reference model state (plain integers)
    int m_cnt;
    bit m_wrap;

    counter_mod_updn #(.WIDTH(WIDTH), .RESET_VAL(WIDTH'(RVAL))) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .up_dn(up_dn),
        .load(load), .load_val(load_val), .modulus(modulus),
        .sat_mode(sat_mode),
`ifdef CNT_SNAPSHOT_EN
        .snap(snap), .snap_val(snap_val),
`endif
        .cnt(cnt), .tc(tc), .wrap(wrap)
    );

    always #5 clk = ~clk;

    // Behavioural rules for one clock edge, on integers.
    function automatic void model_next(input int cur, output int nxt, output bit w);
        int m, lv;
        m  = int'(modulus);
        lv = int'(load_val);
        nxt = cur;
        w   = 1'b0;
        if (clr)       nxt = 0;
        else if (load) nxt = (lv < m) ? lv : m;
        else if (en) begin
            if (up_dn) begin
                if (cur < m)       nxt = cur + 1;
                else if (sat_mode) nxt = m;
                else begin nxt = 0; w = 1'b1; end
            end else begin
                if (cur > m)       nxt = m;
                else if (cur > 0)  nxt = cur - 1;
                else if (sat_mode) nxt = 0;
                else begin nxt = m; w = 1'b1; end
            end
        end
    endfunction

    function automatic bit model_tc();
        return up_dn ? (m_cnt >= int'(modulus)) : (m_cnt == 0);
    endfunction

    // Advance one edge; model follows. Sampling/driving happens 1ns after.
    task automatic tick();
        int n;
        bit w;
        model_next(m_cnt, n, w);
`ifdef CNT_SNAPSHOT_EN
        if (snap) m_snap = m_cnt;
`endif
        @(posedge clk);
        #1;
        m_cnt  = n;
        m_wrap = w;
    endtask

    task automatic idle_inputs();
        clr = 0; en = 0; load = 0; up_dn = 1; sat_mode = 0;
        load_val = '0;
`ifdef CNT_SNAPSHOT_EN
        snap = 0;
`endif
    endtask

    task automatic test_reset();
        tests_run++;
        if (cnt !== WIDTH'(RVAL) || wrap !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_init: cnt=%0d wrap=%0b, required cnt=%0d wrap=0", cnt, wrap, RVAL);
        end
        // move away from RESET_VAL, then pulse reset between edges
        modulus = 8'd100; load_val = 8'd20; load = 1;
        tick();
        load = 0;
        tests_run++;
        if (cnt !== 8'd20) begin
            tests_failed++;
            $display("FAIL reset_preload: cnt=%0d, required 20", cnt);
        end
        #2 rst_n = 0;
        #1;
        m_cnt = RVAL; m_wrap = 0;
        tests_run++;
        if (cnt !== WIDTH'(RVAL) || wrap !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_async: cnt=%0d wrap=%0b, required cnt=%0d wrap=0", cnt, wrap, RVAL);
        end
        #1 rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (cnt !== WIDTH'(RVAL) || wrap !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_hold[%0d]: cnt=%0d wrap=%0b, required cnt=%0d wrap=0", i, cnt, wrap, RVAL);
            end
        end
    endtask

    task automatic test_up_wrap();
        idle_inputs();
        clr = 1; modulus = 8'd9;
        tick();
        clr = 0; en = 1; up_dn = 1; sat_mode = 0;
        for (int k = 1; k <= 10; k++) begin
            tests_run++;
            if (tc !== ((k - 1) == 9)) begin
                tests_failed++;
                $display("FAIL up_wrap_tc[%0d]: tc=%0b, required %0b", k - 1, tc, (k - 1) == 9);
            end
            tick();
            tests_run++;
            if (cnt !== WIDTH'(k % 10) || wrap !== (k == 10)) begin
                tests_failed++;
                $display("FAIL up_wrap[%0d]: cnt=%0d wrap=%0b, required cnt=%0d wrap=%0b", k, cnt, wrap, k % 10, k == 10);
            end
        end
        tick();
        tests_run++;
        if (cnt !== 8'd1 || wrap !== 1'b0) begin
            tests_failed++;
            $display("FAIL up_wrap_after: cnt=%0d wrap=%0b, required cnt=1 wrap=0", cnt, wrap);
        end
    endtask

    task automatic test_down_sat();
        int exp_seq[4] = '{1, 0, 0, 0};
        idle_inputs();
        modulus = 8'd9; load_val = 8'd2; load = 1;
        tick();
        tests_run++;
        if (cnt !== 8'd2) begin
            tests_failed++;
            $display("FAIL down_sat_load: cnt=%0d, required 2", cnt);
        end
        load = 0; up_dn = 0; sat_mode = 1; en = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if (cnt !== WIDTH'(exp_seq[i]) || wrap !== 1'b0 || tc !== (exp_seq[i] == 0)) begin
                tests_failed++;
                $display("FAIL down_sat[%0d]: cnt=%0d wrap=%0b tc=%0b, required cnt=%0d wrap=0 tc=%0b",
                         i, cnt, wrap, tc, exp_seq[i], exp_seq[i] == 0);
            end
        end
    endtask

    task automatic test_priority_clamp();
        idle_inputs();
        modulus = 8'd50; load_val = 8'd200; load = 1; en = 1;
        tick();
        tests_run++;
        if (cnt !== 8'd50) begin
            tests_failed++;
            $display("FAIL load_clamp: cnt=%0d, required 50", cnt);
        end
        clr = 1; load = 1;
        tick();
        tests_run++;
        if (cnt !== 8'd0 || wrap !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_over_load: cnt=%0d wrap=%0b, required cnt=0 wrap=0", cnt, wrap);
        end
        clr = 0; load = 1; load_val = 8'd40;
        tick();
        load = 0; up_dn = 0; sat_mode = 0; modulus = 8'd10;
        tick();
        tests_run++;
        if (cnt !== 8'd10 || wrap !== 1'b0) begin
            tests_failed++;
            $display("FAIL mod_lowered: cnt=%0d wrap=%0b, required cnt=10 wrap=0", cnt, wrap);
        end
    endtask

    task automatic test_full_range();
        idle_inputs();
        modulus = 8'd255; load_val = 8'd255; load = 1;
        tick();
        load = 0; en = 1; up_dn = 1; sat_mode = 0;
        tick();
        tests_run++;
        if (cnt !== 8'd0 || wrap !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_up_wrap: cnt=%0d wrap=%0b, required cnt=0 wrap=1", cnt, wrap);
        end
        up_dn = 0;
        tick();
        tests_run++;
        if (cnt !== 8'd255 || wrap !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_dn_wrap: cnt=%0d wrap=%0b, required cnt=255 wrap=1", cnt, wrap);
        end
    endtask

    task automatic test_mod_zero();
        idle_inputs();
        clr = 1; modulus = 8'd0;
        tick();
        clr = 0; en = 1; up_dn = 1; sat_mode = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (cnt !== 8'd0 || wrap !== 1'b1) begin
                tests_failed++;
                $display("FAIL mod0_wrap[%0d]: cnt=%0d wrap=%0b, required cnt=0 wrap=1", i, cnt, wrap);
            end
        end
        sat_mode = 1;
        tick();
        tests_run++;
        if (cnt !== 8'd0 || wrap !== 1'b0) begin
            tests_failed++;
            $display("FAIL mod0_sat: cnt=%0d wrap=%0b, required cnt=0 wrap=0", cnt, wrap);
        end
    endtask

`ifdef CNT_SNAPSHOT_EN
    task automatic test_snapshot();
        idle_inputs();
        modulus = 8'd20; load_val = 8'd7; load = 1;
        tick();
        load = 0; en = 1; up_dn = 1; snap = 1;
        tick();
        snap = 0;
        tests_run++;
        if (snap_val !== 8'd7 || cnt !== 8'd8) begin
            tests_failed++;
            $display("FAIL snapshot: snap_val=%0d cnt=%0d, required snap_val=7 cnt=8", snap_val, cnt);
        end
        clr = 1;
        tick();
        clr = 0;
        tests_run++;
        if (snap_val !== 8'd7) begin
            tests_failed++;
            $display("FAIL snapshot_clr: snap_val=%0d, required 7", snap_val);
        end
    endtask
`endif

    task automatic test_random();
        int r;
        for (int i = 0; i < 400; i++) begin
            clr      = ($urandom_range(0, 31) == 0);
            load     = ($urandom_range(0, 15) == 0);
            en       = ($urandom_range(0, 7) != 0);
            up_dn    = ($urandom_range(0, 1) == 1);
            sat_mode = ($urandom_range(0, 3) == 0);
            load_val = WIDTH'($urandom_range(0, 255));
            r = $urandom_range(0, 15);
            if (r == 0)      modulus = 8'd0;
            else if (r == 1) modulus = 8'd255;
            else if (r < 6)  modulus = WIDTH'($urandom_range(0, 255));
`ifdef CNT_SNAPSHOT_EN
            snap = ($urandom_range(0, 3) == 0);
`endif
            #1;
            tests_run++;
            if (tc !== model_tc()) begin
                tests_failed++;
                $display("FAIL rand_tc[%0d]: tc=%0b, required %0b", i, tc, model_tc());
            end
            tick();
            tests_run++;
            if (cnt !== WIDTH'(m_cnt) || wrap !== m_wrap) begin
                tests_failed++;
                $display("FAIL rand_step[%0d]: cnt=%0d wrap=%0b, required cnt=%0d wrap=%0b",
                         i, cnt, wrap, m_cnt, m_wrap);
            end
`ifdef CNT_SNAPSHOT_EN
            tests_run++;
            if (snap_val !== WIDTH'(m_snap)) begin
                tests_failed++;
                $display("FAIL rand_snap[%0d]: snap_val=%0d, required %0d", i, snap_val, m_snap);
            end
`endif
        end
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        modulus = 8'd9;
        m_cnt = RVAL; m_wrap = 0;
`ifdef CNT_SNAPSHOT_EN
        m_snap = 0;
`endif
        #12 rst_n = 1;
        test_reset();
        test_up_wrap();
        test_down_sat();
        test_priority_clamp();
        test_full_range();
        test_mod_zero();
`ifdef CNT_SNAPSHOT_EN
        test_snapshot();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/counter_mod_updn.md
Name: counter_mod_updn

Overview:
- Parametrised, WIDTH-bit up/down counter with a programmable modulus, synchronous clear, parallel load, enable, and wrap/saturate mode.
- Next-generation replacement for the fixed 4-bit MOD16 counter.
- General-purpose sequencing element used for timers, address generators and lab datapaths.
- Registered count output plus boundary flags for downstream control.

Parameters:
- WIDTH, 8, counter width in bits (minimum 2).
- RESET_VAL, 0, value cnt takes on async reset (WIDTH bits, must be <= 2^WIDTH-1).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear to 0.
- en  input  1  count enable.
- up_dn  input  1  1 = count up, 0 = count down.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value for load.
- modulus  input  WIDTH  terminal value; count range is 0..modulus inclusive.
- sat_mode  input  1  1 = saturate at boundary, 0 = wrap.
- cnt  output  WIDTH  registered count.
- tc  output  1  combinational terminal-count flag.
- wrap  output  1  registered one-cycle pulse marking a wrap event.

Behaviour:
- Reset:
  - Clock and reset are clk and rst_n; rst_n is asynchronous, active-low.
  - rst_n=0 forces cnt=RESET_VAL and wrap=0 immediately, independent of clk.
  - Deassertion is taken synchronously by the next rising clk edge.
- Priority at each rising edge: clr > load > en > hold.
  - clr=1: cnt<=0, wrap<=0.
  - load=1: cnt<=min(load_val, modulus), wrap<=0.
  - en=1, up_dn=1:
    - cnt<modulus: cnt<=cnt+1.
    - cnt>=modulus: sat_mode=1 gives cnt<=modulus; sat_mode=0 gives cnt<=0 with wrap<=1.
  - en=1, up_dn=0:
    - cnt>modulus (modulus lowered mid-run): cnt<=modulus, no wrap.
    - 0<cnt<=modulus: cnt<=cnt-1.
    - cnt==0: sat_mode=1 gives hold at 0; sat_mode=0 gives cnt<=modulus with wrap<=1.
  - en=0: cnt holds.
  - wrap is 0 in every cycle that does not record a wrap event.
- Latency: one cycle from input to cnt/wrap. wrap is high in the same cycle as the post-wrap cnt value.
- tc = (up_dn && cnt>=modulus) || (!up_dn && cnt==0). tc is independent of en and sat_mode.
- modulus=0: counter is pinned at 0.
  - Wrap mode: every enabled step wraps, so wrap stays high continuously while en=1.
  - Saturate mode: cnt holds at 0 with no wrap.
- modulus=2^WIDTH-1: full natural-binary range. No arithmetic overflow is permitted; comparisons are unsigned at WIDTH bits.
- modulus and up_dn are sampled each cycle and may change at any time. The rules above define the result; there is no hidden state beyond cnt and wrap.
- Reset asserted mid-count overrides everything. The first enabled edge after release counts from RESET_VAL.

Optional Feature:
- Macro: CNT_SNAPSHOT_EN.
- Defined:
  - Adds input snap (1 bit) and output snap_val (WIDTH bits, registered).
  - On a rising edge with snap=1, snap_val<=cnt, i.e. the pre-update value of that same edge. Otherwise snap_val holds.
  - snap_val resets to 0 on rst_n=0 and is unaffected by clr and load.
- Undefined: snap and snap_val ports do not exist; behaviour is otherwise identical.

Test Plan:
- Async reset and hold: WIDTH=8, RESET_VAL=5, pulse rst_n low between edges -> cnt=5 immediately. With en=0 for 3 cycles -> cnt stays 5, wrap=0.
- Up-wrap: modulus=9, up_dn=1, sat_mode=0, en=1 from 0 -> cnt 0..9 then 0. wrap=1 only in the cycle cnt returns to 0. tc=1 while cnt=9.
- Down-saturate: modulus=9, load_val=2 via load, then up_dn=0, sat_mode=1 -> cnt 2,1,0,0,0. wrap never asserts; tc=1 at cnt=0.
- Priority and clamp: load=1, load_val=200, modulus=50 -> cnt=50. clr=1 and load=1 together -> cnt=0. Counting down with cnt=40 then modulus lowered to 10 -> next cnt=10, no wrap.
- Full-range wrap: modulus=255, cnt=255, up -> cnt=0, wrap=1. Down from 0 -> cnt=255, wrap=1.
- CNT_SNAPSHOT_EN: counting up at cnt=7, snap=1 -> snap_val=7 while cnt=8 on the same edge. Subsequent clr -> snap_val remains 7.
